// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the streaming MAC processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        PAUSE  = 2'b00,
        SINGLE = 2'b01,
        CONT   = 2'b10,
        CLEAR  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        HOLD  = 2'b11
    } pe_state_t;

    // Smallest accumulator that cannot wrap over a full window of max-value taps.
    function automatic int min_acc_w(input int data_w, input int kernel_len);
        return 2 * data_w + $clog2(kernel_len);
    endfunction

endpackage

// File: rtl/pe_mac_stream_mult.sv
// Two-stage registered multiplier (operand register, product register).
// Valid and last-tap tags travel alongside the data so the accumulator
// knows when a window closes.
module pe_mult_stage #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  tap_valid,
    input  logic                  tap_last,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  prod_valid,
    output logic                  prod_last,
    output logic [2*DATA_W-1:0]   prod,
    output logic                  busy
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              v1;
    logic              l1;

    // S1: capture operands and tags; flush drops whatever is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            v1  <= 1'b0;
            l1  <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
        end else if (en) begin
            a_q <= a;
            b_q <= b;
            v1  <= tap_valid;
            l1  <= tap_last;
        end
    end

    // S2: full-precision product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else if (flush) begin
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else if (en) begin
            prod       <= {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
            prod_valid <= v1;
            prod_last  <= v1 & l1;
        end
    end

    assign busy = v1 | prod_valid;

endmodule

// File: rtl/pe_mac_stream.sv
// Streaming MAC processing element: accumulates KERNEL_LEN products per
// window and presents one shifted, saturated result per window.
//
// state | meaning
// IDLE  | no window open, waiting for SINGLE or CONT
// RUN   | accepting taps (stalled by a full, unconsumed result)
// DRAIN | last tap of a SINGLE window in flight, no new taps
// HOLD  | SINGLE window finished, waiting for PAUSE/CLEAR
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 8,
    parameter int KERNEL_LEN = 9,
    parameter int ACC_W      = 20,
    parameter int SHIFT      = 0,
    localparam int CNT_W     = $clog2(KERNEL_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pe_in,
    input  logic [DATA_W-1:0] pe_filter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  pe_out,
    output logic              ovf_o,
    output logic              window_done,
    output logic [CNT_W-1:0]  tap_count
);

    if (ACC_W < min_acc_w(DATA_W, KERNEL_LEN)) begin : g_acc_w_check
        $error("pe_mac_stream: ACC_W too small for DATA_W/KERNEL_LEN");
    end
    if (KERNEL_LEN < 2) begin : g_klen_check
        $error("pe_mac_stream: KERNEL_LEN must be at least 2");
    end

    mode_t                mode;
    pe_state_t            state;
    pe_state_t            state_nxt;
    logic                 enable;
    logic                 clear;
    logic                 accept;
    logic                 last_tap;
    logic                 prod_valid;
    logic                 prod_last;
    logic [2*DATA_W-1:0]  prod;
    logic                 busy;
    logic                 load;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     sum;
    logic [ACC_W-1:0]     shifted;
    logic                 sat;

    assign mode     = mode_t'(mode_i);
    assign clear    = (mode == CLEAR);
    assign enable   = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign last_tap = accept && (tap_count == CNT_W'(KERNEL_LEN - 1));

    pe_mult_stage #(.DATA_W(DATA_W)) u_mult (
        .clk        (clk),
        .rst        (rst),
        .en         (enable),
        .flush      (clear),
        .tap_valid  (accept),
        .tap_last   (last_tap),
        .a          (pe_in),
        .b          (pe_filter),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod       (prod),
        .busy       (busy)
    );

    assign load    = enable && prod_valid && prod_last && !clear;
    assign sum     = acc + ACC_W'(prod);
    assign shifted = sum >> SHIFT;
    assign sat     = |(shifted >> OUT_W);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and tap acceptance; CLEAR overrides every state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (mode == SINGLE || mode == CONT) state_nxt = RUN;
                end
                RUN: begin
                    in_ready = enable && (mode == SINGLE || mode == CONT);
                    if (last_tap && mode == SINGLE)
                        state_nxt = DRAIN;
                    else if (mode == PAUSE && tap_count == '0 && !busy)
                        state_nxt = IDLE;
                end
                DRAIN: begin
                    if (load) state_nxt = (mode == CONT) ? RUN : HOLD;
                end
                HOLD: begin
                    if (mode == PAUSE) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Taps accepted in the open window; wraps on the window's last tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tap_count <= '0;
        else if (clear)  tap_count <= '0;
        else if (accept) tap_count <= last_tap ? '0 : tap_count + CNT_W'(1);
    end

    // S3: accumulate; the closing product empties acc as the result loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          acc <= '0;
        else if (clear)                   acc <= '0;
        else if (enable && prod_valid)    acc <= prod_last ? '0 : sum;
    end

    // Result register; a pending result survives CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            pe_out      <= '0;
            ovf_o       <= 1'b0;
            window_done <= 1'b0;
        end else begin
            window_done <= load;
            if (load) begin
                out_valid <= 1'b1;
                pe_out    <= sat ? '1 : OUT_W'(shifted);
                ovf_o     <= sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pe_mac_stream.md
# pe_mac_stream

Parametrised streaming processing element for the convolution datapath: multiplies incoming pixel/weight pairs, accumulates exactly KERNEL_LEN taps per window, and emits one scaled, saturated result per window through a valid/ready output. It supersedes the fixed 8-bit, 9-tap PE. It adds:
- configurable widths and window length
- a full-precision product and accumulator
- single-shot and continuous modes, plus a synchronous clear
- input and output flow control

## Interface
Parameters:
- DATA_W, 8, width of pe_in and pe_filter (unsigned)
- OUT_W, 8, width of pe_out
- KERNEL_LEN, 9, taps per window (≥2)
- ACC_W, 20, accumulator width; elaboration error if < 2*DATA_W + clog2(KERNEL_LEN)
- SHIFT, 0, right shift applied to accumulator before saturation

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode_i  in  2  00 PAUSE, 01 SINGLE, 10 CONT, 11 CLEAR
- in_valid  in  1  tap present
- in_ready  out  1  tap accepted when in_valid && in_ready
- pe_in  in  DATA_W  pixel operand
- pe_filter  in  DATA_W  weight operand
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid && out_ready
- pe_out  out  OUT_W  saturated result
- ovf_o  out  1  result was saturated; qualified by out_valid
- window_done  out  1  one-cycle pulse in the first cycle out_valid rises for a window
- tap_count  out  clog2(KERNEL_LEN+1)  taps accepted in the current window

## Operation
- Pipeline: S1 registers operands; S2 registers the full 2*DATA_W product; S3 adds the product into acc. On the window's last tap, S3 also loads the result register and clears acc.
- Result = min(acc >> SHIFT, 2^OUT_W−1). ovf_o is set when the clamp occurs.
- All arithmetic is unsigned. acc can never wrap, which the ACC_W check guarantees.
- Stall: enable = !(out_valid && !out_ready). S1/S2/S3 advance only when enable is high. A full, undrained result register freezes the whole pipe, so no data is lost.
- tap_count increments on each accepted tap and returns to 0 on acceptance of tap KERNEL_LEN.
- FSM states:
  - IDLE: mode PAUSE with acc empty. Moves to RUN on SINGLE or CONT.
  - RUN: in_ready = enable. On the last tap, moves to DRAIN.
  - DRAIN: last tap in flight, in_ready = 0. When the result is loaded, goes to HOLD (SINGLE) or RUN (CONT).
  - HOLD: in_ready = 0. Goes to IDLE when mode becomes PAUSE or CLEAR.
- CONT mode: windows run back-to-back. The next window's taps may be accepted while the previous result waits, subject to the stall.
- PAUSE mid-window:
  - in_ready = 0.
  - In-flight taps still drain into acc.
  - The partial sum and tap_count are kept; resuming SINGLE or CONT continues the window.
- SINGLE↔CONT switch mid-window: the window continues. The FSM decides the destination state on completion using the mode at that time.
- CLEAR (synchronous, while held):
  - Zeroes acc and tap_count and invalidates S1/S2.
  - FSM goes to IDLE and in_ready = 0.
  - A pending out_valid result is not dropped.
- Reset value of every output and register is 0, including in_ready, out_valid, pe_out, ovf_o, window_done and tap_count. The FSM resets to IDLE.

## Timing
- Latency: last tap accepted in cycle n gives out_valid and window_done in cycle n+3, with no stall.
- Throughput: 1 tap/cycle in CONT with out_ready held high.
- DRAIN costs 2 bubble cycles per window in SINGLE only.
- pe_out and ovf_o are stable while out_valid && !out_ready.
- out_valid falls in the cycle after the handshake, unless a new result loads on the same edge.
- CLEAR asserted in the same cycle as a tap handshake: the tap is discarded.
- rst asserted mid-operation clears everything immediately, without waiting for a clock.

## Structure
- Shared package pe_pkg holds:
  - the mode_t enum (PAUSE, SINGLE, CONT, CLEAR)
  - the pe_state_t enum (IDLE, RUN, DRAIN, HOLD)
  - a function computing the minimum ACC_W
- One sub-module, pe_mult_stage: the registered DATA_W×DATA_W multiplier (S1+S2) with stall enable and flush.
- The FSM, accumulator, saturation and output register live in the top module.

## Test plan
- SINGLE, 9 taps pe_in=2, pe_filter=3, out_ready=1 → pe_out=54, ovf_o=0, window_done pulse 3 cycles after the last tap, then in_ready=0 (HOLD).
- SINGLE, 9 taps 255×255, SHIFT=0 → acc=585225, pe_out=255, ovf_o=1. The same taps with SHIFT=12 → pe_out=142, ovf_o=0.
- CONT, two windows of 1×1 and 2×2, out_ready low for 6 cycles after the first result:
  - in_ready falls while out_valid && !out_ready
  - results are 9 then 36
  - no taps are lost or duplicated
- CLEAR for 1 cycle after 4 taps of 5×5, then 9 taps of 1×1 in SINGLE → pe_out=9, tap_count goes 4→0.
- PAUSE after 5 taps of 3×3, idle 4 cycles with in_valid toggling, resume with 4 taps of 3×3 → pe_out=81 and in_ready=0 during the pause.
- rst pulse mid-window with out_valid pending → all outputs 0 immediately. A following 9-tap window of 1×1 yields 9.
